// File: rtl/alu_cmd_issue_if.sv
// Handshake bundle between the command producer, the issue stage, the ALU and the result consumer.
// The slave modport is the issue stage's view of the bundle.
interface alu_cmd_issue_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [N-1:0]  in_b;
   logic [1:0]    in_op;

   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [1:0]    alu_op;
   logic [N-1:0]  alu_result;

   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_result;
   logic [1:0]    out_op;

   logic [CW-1:0] count;

   modport slave (
      input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
      output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_op, count
   );

   modport master (
      output in_valid, in_a, in_b, in_op, alu_result, out_ready,
      input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_op, count
   );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command FIFO and issue stage in front of a combinational N-bit ALU.
// The FIFO head drives the ALU; its result is captured into a valid/ready output slot.
module alu_cmd_issue #(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   alu_cmd_issue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [1:0]   op;
   } cmd_t;

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_result_q, out_result_d;
   logic [1:0]    out_op_q, out_op_d;

   logic          not_full_c;
   logic          not_empty_c;
   logic          push_c;
   logic          pop_c;
   logic          slot_free_c;
   cmd_t          head_c;

   assign not_full_c  = (count_q != CW'(DEPTH));
   assign not_empty_c = (count_q != CW'(0));
   assign slot_free_c = !out_valid_q || bus.out_ready;
   assign push_c      = bus.in_valid && not_full_c;
   assign pop_c       = not_empty_c && slot_free_c;

   // Head is forced to zero when empty so the ALU never sees stale storage.
   assign head_c      = not_empty_c ? mem_q[rd_ptr_q] : '0;

   assign bus.in_ready   = not_full_c;
   assign bus.alu_a      = head_c.a;
   assign bus.alu_b      = head_c.b;
   assign bus.alu_op     = head_c.op;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_op     = out_op_q;
   assign bus.count      = count_q;

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (push_c && !rst) begin
         mem_q[wr_ptr_q] <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_op_d     = out_op_q;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (pop_c) begin
         rd_ptr_d     = rd_ptr_q + AW'(1);
         out_result_d = bus.alu_result;
         out_op_d     = head_c.op;
         out_valid_d  = 1'b1;
      end else if (slot_free_c) begin
         out_valid_d  = 1'b0;
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_op_q     <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_op_q     <= out_op_d;
      end
   end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Scoreboard bench for alu_cmd_issue: expected results queued on accept, compared on output transfer.
module tb_alu_cmd_issue;
   localparam int unsigned N     = 4;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [3:0] res;
      logic [1:0] op;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   cyc;
   exp_t sb[$];
   int   out_cyc[$];

   alu_cmd_issue_if #(.N(N), .DEPTH(DEPTH)) bus ();

   alu_cmd_issue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   return 4'(a + b);
         2'b10:   return 4'(a - b);
         2'b01:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: inputs are stable between negedge and the next posedge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check("sb_unexpected", 32'(bus.out_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("result", 32'(bus.out_result), 32'(e.res));
               check("op", 32'(bus.out_op), 32'(e.op));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            e.res = alu_ref(bus.in_a, bus.in_b, bus.in_op);
            e.op  = bus.in_op;
            sb.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("send_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int t = 0;
      while ((bus.count != 0 || bus.out_valid) && t < 100) begin
         tick();
         t++;
      end
      check("drain_count", 32'(bus.count), 32'd0);
      check("drain_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      cyc          = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.in_op    = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_result", 32'(bus.out_result), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);

      // Single op and its latency
      bus.out_ready = 1'b1;
      send(4'h3, 4'h5, 2'b00);
      check("lat_valid0", 32'(bus.out_valid), 32'd0);
      check("lat_count1", 32'(bus.count), 32'd1);
      check("head_a", 32'(bus.alu_a), 32'h3);
      tick();
      check("lat_valid1", 32'(bus.out_valid), 32'd1);
      check("single_res", 32'(bus.out_result), 32'h8);
      check("single_op", 32'(bus.out_op), 32'd0);
      check("single_count", 32'(bus.count), 32'd0);
      tick();
      check("single_fall", 32'(bus.out_valid), 32'd0);

      // All opcodes back-to-back, results on consecutive cycles
      out_cyc.delete();
      send(4'hF, 4'h1, 2'b00);
      send(4'h2, 4'h5, 2'b10);
      send(4'hA, 4'h5, 2'b01);
      send(4'hC, 4'hA, 2'b11);
      wait_empty();
      check("b2b_n", 32'(out_cyc.size()), 32'd4);
      for (int i = 1; i < out_cyc.size(); i++) begin
         check("b2b_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
      end

      // Backpressure: first command lands in the slot, four more fill the FIFO
      bus.out_ready = 1'b0;
      send(4'h1, 4'h2, 2'b00);
      send(4'h7, 4'h7, 2'b10);
      send(4'h9, 4'h6, 2'b01);
      send(4'h5, 4'h3, 2'b11);
      send(4'h8, 4'h8, 2'b00);
      bus.in_valid = 1'b1;
      bus.in_a     = 4'hE;
      bus.in_b     = 4'h3;
      bus.in_op    = 2'b10;
      for (int i = 0; i < 3; i++) begin
         check("bp_ready", 32'(bus.in_ready), 32'd0);
         check("bp_count", 32'(bus.count), 32'd4);
         check("bp_hold_v", 32'(bus.out_valid), 32'd1);
         check("bp_hold_r", 32'(bus.out_result), 32'h3);
         check("bp_hold_op", 32'(bus.out_op), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("full_no_push", 32'(bus.in_ready), 32'd0);
      tick();
      check("bp_pop_count", 32'(bus.count), 32'd3);
      @(negedge clk);
      check("bp_reopen", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      wait_empty();

      // Steady push+pop at count 2, enough traffic to wrap the pointers
      bus.out_ready = 1'b0;
      send(4'h4, 4'h4, 2'b00);
      send(4'h6, 4'h2, 2'b10);
      send(4'hB, 4'h4, 2'b01);
      check("pp_count_pre", 32'(bus.count), 32'd2);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         check("pp_count", 32'(bus.count), 32'd2);
      end
      wait_empty();

      // Empty FIFO drives zero onto the ALU
      check("empty_a", 32'(bus.alu_a), 32'd0);
      check("empty_b", 32'(bus.alu_b), 32'd0);
      check("empty_op", 32'(bus.alu_op), 32'd0);

      // Reset mid-stream with three queued and a pending push
      bus.out_ready = 1'b0;
      send(4'h2, 4'h3, 2'b00);
      send(4'h5, 4'h1, 2'b10);
      send(4'hC, 4'h3, 2'b01);
      send(4'h9, 4'h9, 2'b11);
      check("mid_count", 32'(bus.count), 32'd3);
      bus.in_valid = 1'b1;
      rst          = 1'b1;
      tick();
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("mid_rst_count", 32'(bus.count), 32'd0);
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_result", 32'(bus.out_result), 32'd0);
      check("mid_rst_op", 32'(bus.out_op), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);

      bus.out_ready = 1'b1;
      send(4'hD, 4'h4, 2'b10);
      wait_empty();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
